// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX hazard inputs, control outputs and perf counters.
// The pipeline drives through the master modport; the controller uses the slave modport.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned PC_W   = 64,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);

  // ID-stage operand usage
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_uses_rs1;
  logic              id_uses_rs2;

  // EX-stage instruction attributes
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              ex_is_branch;
  logic              ex_branch_taken;
  logic              ex_pred_taken;
  logic [PC_W-1:0]   ex_branch_target;
  logic [PC_W-1:0]   ex_pc_plus4;
  logic              ex_mc_start;

  // Pipeline control
  logic              pc_stall;
  logic              if_id_stall;
  logic              if_flush;
  logic              id_flush;
  logic              id_ex_hold;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              ctrl_state;

  // Performance counters
  logic [CNT_W-1:0]  mispredict_cnt;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_rd, ex_mem_read, ex_is_branch, ex_branch_taken, ex_pred_taken,
    output ex_branch_target, ex_pc_plus4, ex_mc_start,
    input  pc_stall, if_id_stall, if_flush, id_flush, id_ex_hold,
    input  redirect_valid, redirect_pc, ctrl_state,
    input  mispredict_cnt, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_rd, ex_mem_read, ex_is_branch, ex_branch_taken, ex_pred_taken,
    input  ex_branch_target, ex_pc_plus4, ex_mc_start,
    output pc_stall, if_id_stall, if_flush, id_flush, id_ex_hold,
    output redirect_valid, redirect_pc, ctrl_state,
    output mispredict_cnt, stall_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for PC, IF/ID and ID/EX.
// Resolves load-use bubbles, branch-mispredict flush/redirect and multi-cycle EX holds.
// Control outputs are zero-latency combinational; state and perf counters are registered.
module pipeline_hazard_ctrl #(
  parameter int unsigned PC_W   = 64,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_hazard_ctrl_if.slave hz
);

  // mc_cnt must hold MC_LAT-2 (at most 14 for the legal range)
  localparam int unsigned MC_W = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic [MC_W-1:0] MC_INIT = MC_W'(MC_LAT - 2);

  typedef enum logic {
    IDLE    = 1'b0,
    MC_BUSY = 1'b1
  } state_e;

  state_e            state_q;
  state_e            state_d;
  logic [MC_W-1:0]   mc_cnt_q;
  logic [MC_W-1:0]   mc_cnt_d;
  logic [CNT_W-1:0]  mispredict_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic              mispredict;
  logic              rs1_hit;
  logic              rs2_hit;
  logic              load_use;

  logic              pc_stall_c;
  logic              if_id_stall_c;
  logic              if_flush_c;
  logic              id_flush_c;
  logic              id_ex_hold_c;
  logic              redirect_valid_c;
  logic [PC_W-1:0]   redirect_pc_c;
  logic              mispredict_evt_c;

  // Hazard detection terms
  assign mispredict = hz.ex_is_branch & (hz.ex_branch_taken ^ hz.ex_pred_taken);
  assign rs1_hit    = hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd);
  assign rs2_hit    = hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd);
  assign load_use   = hz.ex_mem_read & (hz.ex_rd != REG_AW'(0)) & (rs1_hit | rs2_hit);

  // State, multi-cycle countdown and saturating perf counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      mc_cnt_q         <= '0;
      mispredict_cnt_q <= '0;
      stall_cnt_q      <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
      if (mispredict_evt_c && (mispredict_cnt_q != {CNT_W{1'b1}})) begin
        mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
      end
      if (pc_stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  // Next state and control outputs; everything is quiet while rst is high
  always_comb begin
    state_d          = state_q;
    mc_cnt_d         = mc_cnt_q;
    pc_stall_c       = 1'b0;
    if_id_stall_c    = 1'b0;
    if_flush_c       = 1'b0;
    id_flush_c       = 1'b0;
    id_ex_hold_c     = 1'b0;
    redirect_valid_c = 1'b0;
    redirect_pc_c    = '0;
    mispredict_evt_c = 1'b0;

    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (mispredict) begin
            // Squash the two younger instructions and refetch from the resolved path
            redirect_valid_c = 1'b1;
            if_flush_c       = 1'b1;
            id_flush_c       = 1'b1;
            redirect_pc_c    = hz.ex_branch_taken ? hz.ex_branch_target : hz.ex_pc_plus4;
            mispredict_evt_c = 1'b1;
          end else if (hz.ex_mc_start) begin
            // First EX cycle of a mul/div: freeze the front end and ID/EX
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            id_ex_hold_c  = 1'b1;
            state_d       = MC_BUSY;
            mc_cnt_d      = MC_INIT;
          end else if (load_use) begin
            // Hold fetch/decode and inject one bubble into EX
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            id_flush_c    = 1'b1;
          end
        end

        MC_BUSY: begin
          // Keep holding until the countdown expires; the final EX cycle releases ID/EX
          if (mc_cnt_q != '0) begin
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            id_ex_hold_c  = 1'b1;
            mc_cnt_d      = mc_cnt_q - MC_W'(1);
          end else begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d  = IDLE;
          mc_cnt_d = '0;
        end
      endcase
    end
  end

  // Drive the bundle
  assign hz.pc_stall       = pc_stall_c;
  assign hz.if_id_stall    = if_id_stall_c;
  assign hz.if_flush       = if_flush_c;
  assign hz.id_flush       = id_flush_c;
  assign hz.id_ex_hold     = id_ex_hold_c;
  assign hz.redirect_valid = redirect_valid_c;
  assign hz.redirect_pc    = redirect_pc_c;
  assign hz.ctrl_state     = (state_q == MC_BUSY) & ~rst;
  assign hz.mispredict_cnt = mispredict_cnt_q;
  assign hz.stall_cnt      = stall_cnt_q;

endmodule
